// File: rtl/prenorm.sv
// Iterative left-normalizer for FP multiplier operands: shifts the significand left up to
// STEP bits per cycle, stopping at MSB=1 or EMIN. Optional out_shamt port with PRENORM_SHAMT_EN.
module prenorm #(
    parameter int WSIG = 24,
    parameter int WEXP = 10,
    parameter int STEP = 4,
    parameter int EMIN = -126
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WSIG-1:0] in_sig,
    input  logic [WEXP-1:0] in_exp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WSIG-1:0] out_sig,
    output logic [WEXP-1:0] out_exp,
    output logic            out_zero,
    output logic            out_denorm
`ifdef PRENORM_SHAMT_EN
    ,
    output logic [WEXP-1:0] out_shamt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [WEXP-1:0] EMIN_E = WEXP'(EMIN);
    localparam logic [WEXP:0]   EMIN_X = (WEXP+1)'(EMIN);
    localparam logic [WEXP:0]   STEP_X = (WEXP+1)'(STEP);

    logic [1:0]      state_q, state_d;
    logic [WSIG-1:0] sig_q, sig_d;
    logic [WEXP-1:0] exp_q, exp_d;
    logic            zero_q, zero_d;

    logic [WEXP:0]   lz;
    logic [WEXP:0]   room;
    logic [WEXP:0]   k;
    logic [WSIG-1:0] sig_shl;
    logic [WEXP-1:0] exp_dec;

    // Highest set bit wins: ascending scan, last hit overwrites.
    always_comb begin
        lz = (WEXP+1)'(WSIG);
        for (int unsigned i = 0; i < WSIG; i++) begin
            if (sig_q[i]) lz = (WEXP+1)'(WSIG - 1 - i);
        end
    end

    // Headroom above EMIN in WEXP+1 bits; strictly positive whenever SHIFT is entered.
    always_comb begin
        room = {exp_q[WEXP-1], exp_q} - EMIN_X;
        k    = lz;
        if (STEP_X < k) k = STEP_X;
        if (room < k)   k = room;
        sig_shl = sig_q << k;
        exp_dec = exp_q - k[WEXP-1:0];
    end

`ifdef PRENORM_SHAMT_EN
    logic [WEXP-1:0] shamt_q, shamt_d;
`endif

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        exp_d   = exp_q;
        zero_d  = zero_q;
`ifdef PRENORM_SHAMT_EN
        shamt_d = shamt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sig_d  = in_sig;
                    exp_d  = in_exp;
                    zero_d = 1'b0;
`ifdef PRENORM_SHAMT_EN
                    shamt_d = '0;
`endif
                    if (in_sig == '0) begin
                        zero_d  = 1'b1;
                        exp_d   = '0;
                        state_d = DONE;
                    end else if (in_sig[WSIG-1] || ($signed(in_exp) <= $signed(EMIN_E))) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sig_d = sig_shl;
                exp_d = exp_dec;
`ifdef PRENORM_SHAMT_EN
                shamt_d = shamt_q + k[WEXP-1:0];
`endif
                if (sig_shl[WSIG-1] || (exp_dec == EMIN_E)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
        end
    end

`ifdef PRENORM_SHAMT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shamt_q <= '0;
        else        shamt_q <= shamt_d;
    end
    assign out_shamt = shamt_q;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_sig    = sig_q;
    assign out_exp    = exp_q;
    assign out_zero   = zero_q;
    assign out_denorm = out_valid & ~zero_q & ~sig_q[WSIG-1];

endmodule

// File: tb/tb_prenorm.sv
// Randomized self-checking bench for prenorm against a plain-arithmetic normalization model.
// Define PRENORM_SHAMT_EN for both files to also check out_shamt.
module tb_prenorm;

    localparam int WSIG = 24;
    localparam int WEXP = 10;
    localparam int STEP = 4;
    localparam int EMIN = -126;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [WSIG-1:0] in_sig = '0;
    logic [WEXP-1:0] in_exp = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [WSIG-1:0] out_sig;
    logic [WEXP-1:0] out_exp;
    logic            out_zero;
    logic            out_denorm;
`ifdef PRENORM_SHAMT_EN
    logic [WEXP-1:0] out_shamt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    prenorm #(.WSIG(WSIG), .WEXP(WEXP), .STEP(STEP), .EMIN(EMIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sig(in_sig), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig), .out_exp(out_exp),
        .out_zero(out_zero), .out_denorm(out_denorm)
`ifdef PRENORM_SHAMT_EN
        , .out_shamt(out_shamt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: total shift is min(leading zeros, exp-EMIN), taken STEP bits per cycle.
    function automatic void model(input logic [WSIG-1:0] s, input logic [WEXP-1:0] e,
                                  output logic [WSIG-1:0] rs, output logic [WEXP-1:0] re,
                                  output logic rz, output logic rd, output int sh, output int cyc);
        int ei, lz, room;
        ei  = int'($signed(e));
        rs  = s;
        re  = e;
        rz  = 1'b0;
        sh  = 0;
        cyc = 1;
        if (s == '0) begin
            rz = 1'b1;
            re = '0;
        end else begin
            lz = 0;
            while (s[WSIG-1-lz] == 1'b0) lz++;
            room = ei - EMIN;
            if (lz > 0 && room > 0) begin
                sh  = (lz < room) ? lz : room;
                rs  = s << sh;
                re  = WEXP'(ei - sh);
                cyc = 1 + (sh + STEP - 1) / STEP;
            end
        end
        rd = !rz && !rs[WSIG-1];
    endfunction

    task automatic check_outputs(input string tag, input logic [WSIG-1:0] rs, input logic [WEXP-1:0] re,
                                 input logic rz, input logic rd, input int sh);
        check({tag, ".valid"}, 64'(out_valid), 64'(1));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(0));
        check({tag, ".sig"}, 64'(out_sig), 64'(rs));
        check({tag, ".exp"}, 64'(out_exp), 64'(re));
        check({tag, ".zero"}, 64'(out_zero), 64'(rz));
        check({tag, ".denorm"}, 64'(out_denorm), 64'(rd));
`ifdef PRENORM_SHAMT_EN
        check({tag, ".shamt"}, 64'(out_shamt), 64'(sh));
`else
        if (sh < 0) check({tag, ".shamt_neg"}, 64'(sh), 64'(0));
`endif
    endtask

    task automatic run_op(input string tag, input logic [WSIG-1:0] s, input logic [WEXP-1:0] e,
                          input int hold);
        logic [WSIG-1:0] rs;
        logic [WEXP-1:0] re;
        logic rz, rd;
        int sh, cyc, waited, lat;
        model(s, e, rs, re, rz, rd, sh, cyc);
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, ".accept_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_sig   = s;
        in_exp   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sig   = $urandom;
        in_exp   = WEXP'($urandom);
        lat = 1;
        if (!out_valid) check({tag, ".busy_ready"}, 64'(in_ready), 64'(0));
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(cyc));
        check_outputs(tag, rs, re, rz, rd, sh);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_outputs({tag, ".hold"}, rs, re, rz, rd, sh);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".drained"}, 64'(out_valid), 64'(0));
        check({tag, ".ready_after"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [WSIG-1:0] s;
        logic [WEXP-1:0] e;
        #12;
        check("reset.in_ready", 64'(in_ready), 64'(1));
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.out_sig", 64'(out_sig), 64'(0));
        check("reset.out_exp", 64'(out_exp), 64'(0));
        check("reset.out_zero", 64'(out_zero), 64'(0));
        check("reset.out_denorm", 64'(out_denorm), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("normal", 24'h800000, 10'd5, 0);
        run_op("lz15", 24'h000100, 10'd0, 0);
        run_op("clamp", 24'h000100, WEXP'(-120), 0);
        run_op("zero", 24'h000000, 10'd37, 1);
        run_op("backpressure", 24'h000F00, 10'd20, 3);
        run_op("below_emin", 24'h000010, WEXP'(-200), 0);
        run_op("at_emin", 24'h000001, WEXP'(-126), 0);
        run_op("one_above", 24'h000001, WEXP'(-125), 0);
        run_op("lsb_only", 24'h000001, 10'd100, 0);

        for (int n = 0; n < 200; n++) begin
            s = WSIG'($urandom) >> $urandom_range(0, WSIG);
            case ($urandom_range(0, 2))
                0:       e = WEXP'(EMIN + $urandom_range(0, 30) - 5);
                1:       e = WEXP'($urandom);
                default: e = WEXP'($urandom_range(0, 60));
            endcase
            run_op("rand", s, e, $urandom_range(0, 2));
        end

        // Asynchronous reset while a long shift is in progress
        @(negedge clk);
        in_valid = 1'b1;
        in_sig   = 24'h000001;
        in_exp   = 10'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        check("midshift.busy", 64'(in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check("midshift.in_ready", 64'(in_ready), 64'(1));
        check("midshift.out_valid", 64'(out_valid), 64'(0));
        check("midshift.out_sig", 64'(out_sig), 64'(0));
        check("midshift.out_exp", 64'(out_exp), 64'(0));
        check("midshift.out_zero", 64'(out_zero), 64'(0));
        check("midshift.out_denorm", 64'(out_denorm), 64'(0));
`ifdef PRENORM_SHAMT_EN
        check("midshift.out_shamt", 64'(out_shamt), 64'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", 24'h000300, 10'd10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
